// File: rtl/bf16_pkg.sv
// Shared bfloat16 definitions for the MAC datapath (mul_bf16, add_bf16).
// Holds the bf16 field layout, bias, canonical special encodings and the
// operand class enumeration.
package bf16_pkg;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [6:0] frac;
  } bf16_t;

  localparam int unsigned BF16_BIAS = 127;
  localparam logic [15:0] BF16_QNAN = 16'h7FC0;
  localparam logic [15:0] BF16_PINF = 16'h7F80;
  localparam logic [15:0] BF16_NINF = 16'hFF80;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    NORM = 2'd1,
    INF  = 2'd2,
    NAN  = 2'd3
  } bf16_class_e;

endpackage

// File: rtl/bf16_classify.sv
// Combinational bf16 operand classifier.
// Ports:
//   op_i  [15:0]  bf16 operand
//   cls_o [1:0]   bf16_class_e encoding; subnormals are reported as ZERO
module bf16_classify
  import bf16_pkg::*;
(
  input  logic [15:0] op_i,
  output logic [1:0]  cls_o
);

  bf16_t       op;
  bf16_class_e cls;

  assign op    = op_i;
  assign cls_o = cls;

  always_comb begin
    cls = NORM;
    if (op.exp == 8'hFF) begin
      cls = (op.frac != 7'd0) ? NAN : INF;
    end else if (op.exp == 8'h00) begin
      // Zero and subnormal alike: subnormals are flushed.
      cls = ZERO;
    end
  end

endmodule

// File: rtl/mul_bf16.sv
// Three-stage pipelined bfloat16 multiplier with valid/ready handshake.
// S1 unpacks/classifies, S2 multiplies mantissas, S3 normalizes, rounds and
// packs. Output back-pressure freezes every stage.
// Ports:
//   clk, nRST (sync, active-high)     clock and reset
//   in_valid/in_ready, bf1_in, bf2_in operand pair handshake
//   out_valid/out_ready, bf_out       product handshake
//   overflow, underflow, invalid      per-result flags (valid with out_valid)
// Configuration: define MUL_BF16_RNE_EN for round-to-nearest-even; otherwise
// results are truncated.
module mul_bf16
  import bf16_pkg::*;
#(
  parameter int unsigned STAGES = 3
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] bf1_in,
  input  logic [15:0] bf2_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] bf_out,
  output logic        overflow,
  output logic        underflow,
  output logic        invalid
);

  if (STAGES != 3) begin : g_bad_stages
    $error("mul_bf16: only STAGES = 3 is supported");
  end

  typedef struct packed {
    logic               valid;
    logic               sign;
    logic signed [9:0]  exp;
    logic [7:0]         mant_a;
    logic [7:0]         mant_b;
    logic               spec;
    logic [15:0]        spec_val;
    logic               spec_inv;
  } s1_t;

  typedef struct packed {
    logic               valid;
    logic               sign;
    logic signed [9:0]  exp;
    logic [15:0]        prod;
    logic               spec;
    logic [15:0]        spec_val;
    logic               spec_inv;
  } s2_t;

  typedef struct packed {
    logic        valid;
    logic [15:0] res;
    logic        ovf;
    logic        unf;
    logic        inv;
  } s3_t;

  s1_t s1_n, s1_d, s1_q;
  s2_t s2_n, s2_d, s2_q;
  s3_t s3_n, s3_d, s3_q;

  logic stall;
  assign stall    = s3_q.valid && !out_ready;
  assign in_ready = !stall && !nRST;

  // S1: unpack and classify
  bf16_t       op_a, op_b;
  logic [1:0]  cls_a_raw, cls_b_raw;
  bf16_class_e cls_a, cls_b;

  assign op_a  = bf1_in;
  assign op_b  = bf2_in;
  assign cls_a = bf16_class_e'(cls_a_raw);
  assign cls_b = bf16_class_e'(cls_b_raw);

  bf16_classify u_cls_a (
    .op_i  (bf1_in),
    .cls_o (cls_a_raw)
  );

  bf16_classify u_cls_b (
    .op_i  (bf2_in),
    .cls_o (cls_b_raw)
  );

  always_comb begin
    s1_n          = '0;
    s1_n.valid    = in_valid && in_ready;
    s1_n.sign     = op_a.sign ^ op_b.sign;
    s1_n.exp      = signed'({2'b00, op_a.exp} + {2'b00, op_b.exp} - 10'(BF16_BIAS));
    s1_n.mant_a   = {1'b1, op_a.frac};
    s1_n.mant_b   = {1'b1, op_b.frac};
    s1_n.spec     = 1'b1;
    if (cls_a == NAN || cls_b == NAN) begin
      s1_n.spec_val = BF16_QNAN;
    end else if ((cls_a == INF && cls_b == ZERO) || (cls_a == ZERO && cls_b == INF)) begin
      s1_n.spec_val = BF16_QNAN;
      s1_n.spec_inv = 1'b1;
    end else if (cls_a == INF || cls_b == INF) begin
      s1_n.spec_val = s1_n.sign ? BF16_NINF : BF16_PINF;
    end else if (cls_a == ZERO || cls_b == ZERO) begin
      s1_n.spec_val = {s1_n.sign, 15'd0};
    end else begin
      s1_n.spec = 1'b0;
    end
  end

  // S2: mantissa multiply
  always_comb begin
    s2_n          = '0;
    s2_n.valid    = s1_q.valid;
    s2_n.sign     = s1_q.sign;
    s2_n.exp      = s1_q.exp;
    s2_n.prod     = {8'd0, s1_q.mant_a} * {8'd0, s1_q.mant_b};
    s2_n.spec     = s1_q.spec;
    s2_n.spec_val = s1_q.spec_val;
    s2_n.spec_inv = s1_q.spec_inv;
  end

  // S3: normalize, round, pack
  logic [6:0]        frac;
  logic signed [9:0] e;

`ifdef MUL_BF16_RNE_EN
  logic       guard, sticky, round_up;
  logic [7:0] frac_rnd;
`else
  logic       unused_lsbs;
  assign unused_lsbs = ^s2_q.prod[6:0];
`endif

  always_comb begin
    if (s2_q.prod[15]) begin
      frac = s2_q.prod[14:8];
      e    = s2_q.exp + 10'sd1;
    end else begin
      frac = s2_q.prod[13:7];
      e    = s2_q.exp;
    end
`ifdef MUL_BF16_RNE_EN
    guard    = s2_q.prod[15] ? s2_q.prod[7] : s2_q.prod[6];
    sticky   = s2_q.prod[15] ? |s2_q.prod[6:0] : |s2_q.prod[5:0];
    round_up = guard && (sticky || frac[0]);
    frac_rnd = {1'b0, frac} + {7'd0, round_up};
    if (frac_rnd[7]) begin
      // Mantissa rolled over to 10.0000000: renormalize.
      frac = 7'd0;
      e    = e + 10'sd1;
    end else begin
      frac = frac_rnd[6:0];
    end
`endif

    s3_n       = '0;
    s3_n.valid = s2_q.valid;
    if (s2_q.valid) begin
      if (s2_q.spec) begin
        s3_n.res = s2_q.spec_val;
        s3_n.inv = s2_q.spec_inv;
      end else if (e >= 10'sd255) begin
        s3_n.res = {s2_q.sign, 8'hFF, 7'd0};
        s3_n.ovf = 1'b1;
      end else if (e <= 10'sd0) begin
        s3_n.res = {s2_q.sign, 15'd0};
        s3_n.unf = 1'b1;
      end else begin
        s3_n.res = {s2_q.sign, e[7:0], frac};
      end
    end
  end

  // Whole pipeline freezes on output back-pressure.
  always_comb begin
    s1_d = s1_q;
    s2_d = s2_q;
    s3_d = s3_q;
    if (!stall) begin
      s1_d = s1_n;
      s2_d = s2_n;
      s3_d = s3_n;
    end
  end

  always_ff @(posedge clk) begin
    if (nRST) begin
      s1_q <= '0;
      s2_q <= '0;
      s3_q <= '0;
    end else begin
      s1_q <= s1_d;
      s2_q <= s2_d;
      s3_q <= s3_d;
    end
  end

  assign out_valid = s3_q.valid;
  assign bf_out    = s3_q.res;
  assign overflow  = s3_q.ovf;
  assign underflow = s3_q.unf;
  assign invalid   = s3_q.inv;

endmodule

// File: doc/mul_bf16.md
# mul_bf16

Pipelined bfloat16 multiplier that produces the products consumed by `add_bf16` in the systolic-array MAC datapath. It accepts one operand pair per cycle under a valid/ready handshake, delivers the product three cycles later, and stalls the whole pipeline under output back-pressure. Subnormals flush to zero, and the exception flags use the same encoding as the downstream adder, so the two blocks chain directly.

## Interface
Parameters:
- `STAGES`, 3, pipeline depth. Only 3 is supported; elaboration fails on any other value.

Ports:
- `clk`  in  1  rising-edge clock
- `nRST`  in  1  synchronous, active-high reset (1 = reset)
- `in_valid`  in  1  operand pair present
- `in_ready`  out  1  pair accepted when `in_valid && in_ready`
- `bf1_in`  in  16  operand A, bf16
- `bf2_in`  in  16  operand B, bf16
- `out_valid`  out  1  product present
- `out_ready`  in  1  downstream accepts product
- `bf_out`  out  16  product, bf16
- `overflow`  out  1  finite×finite result saturated to ±inf
- `underflow`  out  1  nonzero finite result flushed to ±0
- `invalid`  out  1  inf×0

## Operation
- S1, unpack:
  - Classify each operand as zero, subnormal, normal, inf or NaN.
  - Subnormal operands are treated as zero.
  - sign = sA ^ sB.
  - Exponent sum e = eA + eB − 127, as a 10-bit signed value.
- S2, multiply: 8×8 product of the mantissas with the hidden bit restored, giving a 16-bit result P.
- S3, normalize and round:
  - If P[15] = 1: frac = P[14:8], guard = P[7], sticky = |P[6:0], e += 1.
  - Otherwise: frac = P[13:7], guard = P[6], sticky = |P[5:0].
  - Round to nearest even: increment when guard && (sticky || frac[0]).
  - A carry out of frac sets frac = 0 and e += 1.
  - e ≥ 255: result is {sign, 0xFF, 0}, overflow = 1.
  - e ≤ 0: result is {sign, 0, 0}, underflow = 1.
- Special cases, decided in S1 and carried down the pipeline (they override S3):
  - Any NaN operand: 0x7FC0, all flags 0.
  - inf×zero: 0x7FC0, invalid = 1.
  - inf×nonzero: signed inf, flags 0.
  - zero×finite: signed zero, flags 0.
- Flags are per-result: they are valid only while `out_valid` is high and are not sticky.

## Timing
- Latency: a pair accepted in cycle N appears with `out_valid` high in cycle N+3, provided no stall occurs.
- Throughput: one result per cycle.
- Stall = `out_valid && !out_ready`. While stalled, every stage register holds its value.
- `in_ready` = !stall && !`nRST`, a combinational function of `out_ready`.
- Bubbles (stages with valid = 0) advance normally; the block does not collapse bubbles.
- `out_valid`, `bf_out` and the flags stay stable while stalled.
- Reset, including mid-operation: on the next edge all stage valids clear, `out_valid` = 0, `bf_out` = 0x0000 and all flags = 0. In-flight results are dropped.
- `in_valid` together with `nRST`: the operand pair is ignored.

## Configuration
- `MUL_BF16_RNE_EN` defined: round to nearest even as described under Operation.
- `MUL_BF16_RNE_EN` undefined: truncation. Guard and sticky are ignored, so no rounding carry can occur; overflow and underflow checks use the unrounded e.

## Structure
- `bf16_pkg` holds shared definitions used by both `add_bf16` and this block:
  - `bf16_t` packed struct {sign, exp[7:0], frac[6:0]}
  - `BF16_BIAS` = 127
  - `BF16_QNAN` = 16'h7FC0
  - `BF16_PINF` = 16'h7F80
  - `BF16_NINF` = 16'hFF80
  - class enum {ZERO, NORM, INF, NAN}
- Sub-module `bf16_classify` (combinational): takes a `bf16_t` and returns its class, with subnormal mapped to ZERO. S1 instantiates it twice, one per operand.

## Test plan
- 3FC0×4020 (1.5×2.5) → 0x4070 three cycles after acceptance, all flags 0.
- 3FC1×3FC1 → 0x4012 with `MUL_BF16_RNE_EN` defined, 0x4011 without it.
- 7F7F×4000 → 0x7F80 with overflow = 1; C000×3F80 → 0xC000; 0080×0080 → 0x0000 with underflow = 1.
- 7F80×0000 → 0x7FC0 with invalid = 1; 7FC0×3F80 → 0x7FC0 with invalid = 0; 8000×4000 → 0x8000.
- Back-pressure:
  - Stream 6 back-to-back pairs and hold `out_ready` low for 5 cycles from the first `out_valid`.
  - Required: `in_ready` falls in the same cycle, `bf_out` holds.
  - Required: all 6 results arrive in order, with no loss and no duplicates.
- Assert `nRST` for one cycle with 3 pairs in flight → next cycle `out_valid` = 0; the next accepted pair emerges after exactly 3 cycles.
